hpdcache_data_upsize: RTL

//  Width up-converter FIFO: accepts narrow WR_WIDTH words, packs them in arrival order

---
 rtl/hpdcache_data_upsize.sv | 105 ++++++++++
 1 files changed

// File: rtl/hpdcache_data_upsize.sv
// Width up-converter FIFO: packs narrow write words in arrival order into wide
// entries and pops one whole wide entry per read; wlast_i closes an entry early.
module hpdcache_data_upsize #(
  parameter int unsigned WR_WIDTH = 64,
  parameter int unsigned RD_WIDTH = 256,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                w_i,
  input  logic                wlast_i,
  output logic                wok_o,
  input  logic [WR_WIDTH-1:0] wdata_i,
  input  logic                r_i,
  output logic                rok_o,
  output logic [RD_WIDTH-1:0] rdata_o
);

  localparam int unsigned WR_WORDS      = RD_WIDTH / WR_WIDTH;
  localparam int unsigned WORDCNT_WIDTH = (WR_WORDS > 2) ? $clog2(WR_WORDS) : 1;
  localparam int unsigned PTR_WIDTH     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned USED_WIDTH    = $clog2(DEPTH) + 1;

  logic [RD_WIDTH-1:0]      mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]     wrptr_q, wrptr_d;
  logic [PTR_WIDTH-1:0]     rdptr_q, rdptr_d;
  logic [USED_WIDTH-1:0]    used_q, used_d;
  logic [WORDCNT_WIDTH-1:0] wcnt_q, wcnt_d;

  logic w_acc;
  logic r_acc;
  logic commit;

  // The entry under fill is not counted in used_q, so it never gates a read.
  assign wok_o   = (used_q < USED_WIDTH'(DEPTH));
  assign rok_o   = (used_q != '0);
  assign rdata_o = mem_q[rdptr_q];

  assign w_acc  = w_i & wok_o;
  assign r_acc  = r_i & rok_o;
  assign commit = w_acc & (wlast_i | (wcnt_q == WORDCNT_WIDTH'(WR_WORDS - 1)));

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    used_d  = used_q;
    wcnt_d  = wcnt_q;
    if (w_acc) begin
      wcnt_d = commit ? '0 : wcnt_q + WORDCNT_WIDTH'(1);
    end
    if (commit) begin
      wrptr_d = (wrptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : wrptr_q + PTR_WIDTH'(1);
    end
    if (r_acc) begin
      rdptr_d = (rdptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : rdptr_q + PTR_WIDTH'(1);
    end
    case ({commit, r_acc})
      2'b10:   used_d = used_q + USED_WIDTH'(1);
      2'b01:   used_d = used_q - USED_WIDTH'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      used_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      used_q  <= used_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Word 0 of a new entry also clears the upper words, so an early close is zero-filled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (w_acc) begin
      if (wcnt_q == '0) begin
        mem_q[wrptr_q] <= {{(RD_WIDTH - WR_WIDTH){1'b0}}, wdata_i};
      end else begin
        mem_q[wrptr_q][wcnt_q * WR_WIDTH +: WR_WIDTH] <= wdata_i;
      end
    end
  end

  generate
    if (WR_WIDTH == 0 || RD_WIDTH <= WR_WIDTH || (RD_WIDTH % WR_WIDTH) != 0 || DEPTH == 0)
    begin : g_bad_params
      $error("hpdcache_data_upsize: illegal WR_WIDTH/RD_WIDTH/DEPTH");
    end
  endgenerate

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_acc && used_q == USED_WIDTH'(DEPTH)))
        else $error("hpdcache_data_upsize: write accepted while full");
    end
  end

endmodule
